// File: rtl/gpu_cmd_sequencer.sv
// Wishbone write master that walks a command ROM after a start pulse and issues one
// single-beat register write per entry, with an optional idle delay after each write.
module gpu_cmd_sequencer #(
  parameter int NUM_CMDS = 16,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DLY_W    = 16,
  parameter int TIMEOUT  = 255,
  localparam int IDX_W   = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IDX_W-1:0]  cmd_idx_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [3:0]        cmd_sel_i,
  input  logic [DLY_W-1:0]  cmd_dly_i,
  input  logic              cmd_last_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_WRITE, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              start_reg;
  logic              bus_reg;
  logic [3:0]        sel_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [DATA_W-1:0] dat_reg;
  logic [DLY_W-1:0]  dly_cnt_reg;
  logic              last_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;
  logic              at_end;
  logic              can_start;

  assign at_end    = last_reg || (idx_reg == LAST_IDX);
  assign can_start = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERROR);

  assign cmd_idx_o = idx_reg;
  assign wb_cyc_o  = bus_reg;
  assign wb_stb_o  = bus_reg;
  assign wb_we_o   = bus_reg;
  assign wb_sel_o  = sel_reg;
  assign wb_adr_o  = adr_reg;
  assign wb_dat_o  = dat_reg;
  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign error_o   = error_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      start_reg   <= 1'b0;
      bus_reg     <= 1'b0;
      sel_reg     <= '0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      dly_cnt_reg <= '0;
      last_reg    <= 1'b0;
      to_cnt_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      // Pulses arriving while a sequence runs are discarded, not queued.
      start_reg <= start && can_start;
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_reg) begin
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: state_reg <= S_LATCH;
        S_LATCH: begin
          adr_reg     <= cmd_addr_i;
          dat_reg     <= cmd_data_i;
          sel_reg     <= cmd_sel_i;
          dly_cnt_reg <= cmd_dly_i;
          last_reg    <= cmd_last_i;
          to_cnt_reg  <= '0;
          bus_reg     <= 1'b1;
          state_reg   <= S_WRITE;
        end
        S_WRITE: begin
          if (wb_ack_i) begin
            bus_reg <= 1'b0;
            if (dly_cnt_reg != '0) begin
              state_reg <= S_DELAY;
            end else if (at_end) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= S_FETCH;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            bus_reg   <= 1'b0;
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_ERROR;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        S_DELAY: begin
          if (dly_cnt_reg == DLY_W'(1)) begin
            if (at_end) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= S_FETCH;
            end
          end else begin
            dly_cnt_reg <= dly_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Bench for gpu_cmd_sequencer: ROM and Wishbone slave models, random command tables
// checked against a cycle-arithmetic model of the expected write stream.
module tb_gpu_cmd_sequencer;

  localparam int NC = 16;
  localparam int TO = 255;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  cmd_idx;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_sel;
  logic [15:0] cmd_dly;
  logic        cmd_last;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;
  logic        wb_ack;
  logic        busy, done, error;

  gpu_cmd_sequencer #(
    .NUM_CMDS(NC), .ADDR_W(32), .DATA_W(32), .DLY_W(16), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_idx_o(cmd_idx), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cmd_sel_i(cmd_sel), .cmd_dly_i(cmd_dly), .cmd_last_i(cmd_last),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_ack_i(wb_ack),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Command table and its synchronous ROM model (one cycle read latency)
  logic [31:0] t_addr [NC];
  logic [31:0] t_data [NC];
  logic [3:0]  t_sel  [NC];
  logic [15:0] t_dly  [NC];
  logic        t_last [NC];

  always @(posedge clk) begin
    cmd_addr <= t_addr[cmd_idx];
    cmd_data <= t_data[cmd_idx];
    cmd_sel  <= t_sel[cmd_idx];
    cmd_dly  <= t_dly[cmd_idx];
    cmd_last <= t_last[cmd_idx];
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave + monitor, evaluated on the falling edge
  int          ack_lat;
  bit          stray_ack;
  int          hi = 0;
  bit          prev_stb = 0;
  int          proto_err = 0;
  int          rise_q[$];
  int          hi_q[$];
  logic [31:0] adr_q[$];
  logic [31:0] dat_q[$];
  logic [3:0]  sel_q[$];

  always @(negedge clk) begin
    if (wb_stb === 1'b1) begin
      if (!prev_stb) begin
        rise_q.push_back(cyc_cnt);
        adr_q.push_back(wb_adr);
        dat_q.push_back(wb_dat);
        sel_q.push_back(wb_sel);
        hi = 0;
      end else if (adr_q.size() > 0) begin
        if (wb_adr !== adr_q[$] || wb_dat !== dat_q[$] || wb_sel !== sel_q[$]) proto_err++;
      end
      if (wb_cyc !== 1'b1 || wb_we !== 1'b1) proto_err++;
      hi++;
      wb_ack = (ack_lat != 0) && (hi == ack_lat);
      prev_stb = 1'b1;
    end else begin
      if (prev_stb && adr_q.size() > 0) begin
        hi_q.push_back(hi);
        $display("wb write adr=%08h dat=%08h sel=%h stb_cycles=%0d", adr_q[$], dat_q[$], sel_q[$], hi);
      end
      if (wb_cyc === 1'b1 || wb_we === 1'b1) proto_err++;
      wb_ack = stray_ack;
      prev_stb = 1'b0;
    end
  end

  int total = 0;
  int bad = 0;
  int t0;
  bit timed_out;

  int          exp_rise[$];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic [3:0]  exp_sel[$];
  int          exp_last_idx;

  task automatic clear_mon();
    rise_q.delete(); hi_q.delete(); adr_q.delete(); dat_q.delete(); sel_q.delete();
    proto_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_end(output bit to_flag);
    to_flag = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) begin
        to_flag = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Model: first strobe 3 cycles after start; each next strobe = ack edge + dly + 2.
  function automatic void build_expected(input int start_cyc, input int lat);
    int t;
    exp_rise.delete(); exp_adr.delete(); exp_dat.delete(); exp_sel.delete();
    t = start_cyc + 3;
    for (int i = 0; i < NC; i++) begin
      exp_rise.push_back(t);
      exp_adr.push_back(t_addr[i]);
      exp_dat.push_back(t_data[i]);
      exp_sel.push_back(t_sel[i]);
      exp_last_idx = i;
      if (t_last[i]) break;
      t = t + lat + int'(t_dly[i]) + 2;
    end
  endfunction

  task automatic load_basic();
    for (int i = 0; i < NC; i++) begin
      t_addr[i] = 32'h100 + 32'(i * 4); t_data[i] = 32'(i); t_sel[i] = 4'hF;
      t_dly[i] = 16'd0; t_last[i] = 1'b0;
    end
    t_addr[0] = 32'h10; t_data[0] = 32'hA5; t_sel[0] = 4'hF;
    t_addr[1] = 32'h14; t_data[1] = 32'h5A; t_sel[1] = 4'h3;
    t_addr[2] = 32'h18; t_data[2] = 32'h01; t_sel[2] = 4'hF; t_last[2] = 1'b1;
  endtask

  task automatic load_scenario(input int sc, output int lat);
    int last_at;
    for (int i = 0; i < NC; i++) begin
      t_addr[i] = $urandom() & 32'hFFFF_FFFC;
      t_data[i] = $urandom();
      t_sel[i]  = 4'($urandom_range(1, 15));
      t_dly[i]  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 6)) : 16'd0;
      t_last[i] = 1'b0;
    end
    lat = int'($urandom_range(1, 4));
    if (sc == 0) begin
      load_basic(); lat = 1;
    end else if (sc == 1) begin
      load_basic(); t_dly[0] = 16'd5; lat = 1;
    end else if (sc == 7) begin
      for (int i = 0; i < NC; i++) t_dly[i] = 16'd0;
      lat = 1;
    end else if (sc == 8) begin
      t_last[1] = 1'b1; lat = TO;
    end else begin
      last_at = int'($urandom_range(1, 16));
      if (last_at < NC) t_last[last_at] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ack_lat = 1; stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin bad++; $display("FAIL reset_bus got=%b want=000", {wb_cyc, wb_stb, wb_we}); end
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, done, error}); end
    total++; if (cmd_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", cmd_idx); end
    total++; if ({wb_adr, wb_dat, wb_sel} !== 68'd0) begin bad++; $display("FAIL reset_fields got=%h want=0", {wb_adr, wb_dat, wb_sel}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sequences();
    int lat;
    for (int sc = 0; sc < 9; sc++) begin
      load_scenario(sc, lat);
      ack_lat = lat;
      clear_mon();
      pulse_start();
      wait_end(timed_out);
      build_expected(t0, lat);
      total++; if (timed_out) begin bad++; $display("FAIL seq%0d_end got=timeout want=done", sc); end
      total++; if (rise_q.size() != exp_adr.size()) begin bad++; $display("FAIL seq%0d_count got=%0d want=%0d", sc, rise_q.size(), exp_adr.size()); end
      for (int k = 0; k < exp_adr.size() && k < rise_q.size(); k++) begin
        total++;
        if (adr_q[k] !== exp_adr[k] || dat_q[k] !== exp_dat[k] || sel_q[k] !== exp_sel[k])
          begin bad++; $display("FAIL seq%0d_w%0d got=%h/%h/%h want=%h/%h/%h", sc, k, adr_q[k], dat_q[k], sel_q[k], exp_adr[k], exp_dat[k], exp_sel[k]); end
        total++;
        if (rise_q[k] != exp_rise[k]) begin bad++; $display("FAIL seq%0d_rise%0d got=%0d want=%0d", sc, k, rise_q[k], exp_rise[k]); end
        total++;
        if (k >= hi_q.size() || hi_q[k] != lat) begin bad++; $display("FAIL seq%0d_hold%0d got=%0d want=%0d", sc, k, (k < hi_q.size()) ? hi_q[k] : -1, lat); end
      end
      total++; if ({busy, done, error} !== 3'b010) begin bad++; $display("FAIL seq%0d_status got=%b want=010", sc, {busy, done, error}); end
      total++; if (int'(cmd_idx) != exp_last_idx) begin bad++; $display("FAIL seq%0d_idx got=%0d want=%0d", sc, cmd_idx, exp_last_idx); end
      total++; if (proto_err != 0) begin bad++; $display("FAIL seq%0d_protocol got=%0d want=0", sc, proto_err); end
    end
  endtask

  task automatic test_timeout();
    load_basic();
    ack_lat = 0;
    clear_mon();
    pulse_start();
    wait_end(timed_out);
    repeat (40) @(negedge clk);
    total++; if (timed_out) begin bad++; $display("FAIL timeout_end got=hang want=error"); end
    total++; if (rise_q.size() != 1) begin bad++; $display("FAIL timeout_writes got=%0d want=1", rise_q.size()); end
    total++; if (hi_q.size() < 1 || hi_q[0] != TO) begin bad++; $display("FAIL timeout_hold got=%0d want=%0d", (hi_q.size() > 0) ? hi_q[0] : -1, TO); end
    total++; if ({busy, done, error} !== 3'b001) begin bad++; $display("FAIL timeout_status got=%b want=001", {busy, done, error}); end
    ack_lat = 1;
    clear_mon();
    pulse_start();
    total++; if ({busy, error} !== 2'b10) begin bad++; $display("FAIL restart_clear got=%b want=10", {busy, error}); end
    wait_end(timed_out);
    total++; if (rise_q.size() != 3 || adr_q[0] !== 32'h10) begin bad++; $display("FAIL restart_writes got=%0d want=3", rise_q.size()); end
    total++; if ({busy, done, error} !== 3'b010) begin bad++; $display("FAIL restart_status got=%b want=010", {busy, done, error}); end
  endtask

  task automatic test_stray_and_busy_start();
    // Stray acks while DONE
    stray_ack = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    total++; if (rise_q.size() != 0 || {busy, done, error} !== 3'b010 || cmd_idx !== 4'd2)
      begin bad++; $display("FAIL stray_done got=%0d/%b/%0d want=0/010/2", rise_q.size(), {busy, done, error}, cmd_idx); end
    // Stray acks while IDLE
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    stray_ack = 1'b1;
    repeat (20) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    total++; if (rise_q.size() != 0 || {busy, done, error, wb_stb} !== 4'b0000 || cmd_idx !== 4'd0)
      begin bad++; $display("FAIL stray_idle got=%0d/%b want=0/0000", rise_q.size(), {busy, done, error, wb_stb}); end
    // Extra start pulses during a running sequence
    load_basic();
    ack_lat = 3;
    clear_mon();
    pulse_start();
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
    end
    wait_end(timed_out);
    build_expected(t0, 3);
    total++; if (rise_q.size() != 3) begin bad++; $display("FAIL busy_start_count got=%0d want=3", rise_q.size()); end
    total++; if (rise_q.size() == 3 && (rise_q[0] != exp_rise[0] || rise_q[2] != exp_rise[2]))
      begin bad++; $display("FAIL busy_start_timing got=%0d,%0d want=%0d,%0d", rise_q[0], rise_q[2], exp_rise[0], exp_rise[2]); end
    repeat (10) @(negedge clk);
    total++; if (rise_q.size() != 3 || {busy, done} !== 2'b01) begin bad++; $display("FAIL busy_start_after got=%0d/%b want=3/01", rise_q.size(), {busy, done}); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_basic();
    ack_lat = 0;
    clear_mon();
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wb_stb === 1'b1) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_stb got=0 want=1"); end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if ({wb_cyc, wb_stb, wb_we, busy} !== 4'b0000) begin bad++; $display("FAIL rstmid_async got=%b want=0000", {wb_cyc, wb_stb, wb_we, busy}); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (rise_q.size() != 1 || {wb_stb, busy, done, error} !== 4'b0000)
      begin bad++; $display("FAIL rstmid_resume got=%0d/%b want=1/0000", rise_q.size(), {wb_stb, busy, done, error}); end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_timeout();
    test_stray_and_busy_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
